// File: rtl/oflow_pe_ctrl_pkg.sv
// oflow_pe_ctrl_pkg
// Shared types and helpers for the per-PE object-pass sequencer.
//   pe_ctrl_state_t    sequencer state encoding
//   ROW_LEN_DEF        default width of the buffer row select
//   OBJ_CNT_W_DEF      default width of the previous-frame object count
//   rows_total_calc()  number of buffer rows holding n objects (two per row),
//                      saturated at the buffer depth 2^row_len
package oflow_pe_ctrl_pkg;

  localparam int ROW_LEN_DEF   = 6;
  localparam int OBJ_CNT_W_DEF = 7;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FE        = 3'd1,
    S_REG_START = 3'd2,
    S_COMPARE   = 3'd3,
    S_REG_WAIT  = 3'd4,
    S_DONE      = 3'd5
  } pe_ctrl_state_t;

  // ceil(n/2) written as floor + odd bit so it never needs a wider adder.
  function automatic int rows_total_calc(input int n, input int row_len);
    int half;
    half = (n >>> 1) + (n & 1);
    if (half > (1 << row_len)) half = 1 << row_len;
    return half;
  endfunction

endpackage

// File: rtl/oflow_pe_ctrl.sv
// oflow_pe_ctrl
// Per-PE sequencer: runs feature extraction, then (for frames with history)
// registration against the previous-frame objects, stepping the buffer row
// pointer once per similarity-metric completion, then reports done_pe.
//
// Ports:
//   clk                       clock, rising edge
//   reset_N                   synchronous active-high reset
//   start_pe                  one-cycle start from the core FSM (ignored while busy)
//   frame_num                 0 = first frame, 1 = later frame (sampled on start_pe)
//   num_prev_objs             previous-frame object count (sampled on start_pe)
//   done_fe                   feature extraction finished
//   done_similarity_metric_i  current row pair scored
//   done_registration         registration result final
//   start_fe                  one-cycle pulse to feature extraction
//   start_registration        one-cycle pulse to registration
//   row_sel_to_pe             buffer row feeding the PE
//   done_pe                   one-cycle completion pulse
//   busy                      high from accepted start_pe through the done_pe cycle
//   wdt_err                   watchdog expiry pulse (OFLOW_PE_CTRL_WATCHDOG_EN only)
//
// Build option: define OFLOW_PE_CTRL_WATCHDOG_EN to add a WDT_W-bit watchdog
// that forces DONE when any wait state stalls for 2^WDT_W cycles.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for start_pe
// S_FE        | feature extraction running, waiting for done_fe
// S_REG_START | start_registration pulse cycle, row pointer at 0
// S_COMPARE   | stepping rows on each done_similarity_metric_i
// S_REG_WAIT  | all rows scored, waiting for done_registration
// S_DONE      | done_pe pulse cycle, back to idle next
module oflow_pe_ctrl
  import oflow_pe_ctrl_pkg::*;
#(
  parameter int ROW_LEN   = ROW_LEN_DEF,
  parameter int OBJ_CNT_W = OBJ_CNT_W_DEF
`ifdef OFLOW_PE_CTRL_WATCHDOG_EN
  ,
  parameter int WDT_W     = 10
`endif
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 start_pe,
  input  logic                 frame_num,
  input  logic [OBJ_CNT_W-1:0] num_prev_objs,
  input  logic                 done_fe,
  input  logic                 done_similarity_metric_i,
  input  logic                 done_registration,
  output logic                 start_fe,
  output logic                 start_registration,
  output logic [ROW_LEN-1:0]   row_sel_to_pe,
  output logic                 done_pe,
  output logic                 busy
`ifdef OFLOW_PE_CTRL_WATCHDOG_EN
  ,
  output logic                 wdt_err
`endif
);

  pe_ctrl_state_t     state;
  logic               frame_lat;
  logic               reg_done_lat;
  logic [ROW_LEN:0]   rows_total;
  logic [ROW_LEN:0]   rows_total_d;
  logic [ROW_LEN:0]   row_nxt;
  logic               cmp_last;
  logic               fe_exit;
  logic               cmp_exit;
  logic               rw_exit;
  logic               wdt_hit;

  assign rows_total_d = (ROW_LEN+1)'(rows_total_calc(int'(num_prev_objs), ROW_LEN));

  // One bit wider than the row select so the last-row compare sees rows_total
  // equal to the full buffer depth.
  assign row_nxt  = {1'b0, row_sel_to_pe} + {{ROW_LEN{1'b0}}, 1'b1};
  assign cmp_last = (row_nxt == rows_total);

  assign fe_exit  = (state == S_FE) && done_fe;
  assign cmp_exit = (state == S_COMPARE) && done_similarity_metric_i && cmp_last;
  assign rw_exit  = (state == S_REG_WAIT) && (done_registration || reg_done_lat);

`ifdef OFLOW_PE_CTRL_WATCHDOG_EN
  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_watch;

  assign wdt_watch = (state == S_FE) || (state == S_COMPARE) || (state == S_REG_WAIT);
  assign wdt_hit   = wdt_watch && (wdt_cnt == '1);

  // Restarts on every state change so each wait gets its own full budget.
  always_ff @(posedge clk) begin
    if (reset_N) begin
      wdt_cnt <= '0;
    end else if (!wdt_watch || fe_exit || cmp_exit || rw_exit || wdt_hit) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + WDT_W'(1);
    end
  end
`else
  assign wdt_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset_N) begin
      state              <= S_IDLE;
      start_fe           <= 1'b0;
      start_registration <= 1'b0;
      row_sel_to_pe      <= '0;
      done_pe            <= 1'b0;
      busy               <= 1'b0;
      frame_lat          <= 1'b0;
      rows_total         <= '0;
      reg_done_lat       <= 1'b0;
`ifdef OFLOW_PE_CTRL_WATCHDOG_EN
      wdt_err            <= 1'b0;
`endif
    end else begin
      start_fe           <= 1'b0;
      start_registration <= 1'b0;
      done_pe            <= 1'b0;
`ifdef OFLOW_PE_CTRL_WATCHDOG_EN
      wdt_err            <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start_pe) begin
            frame_lat    <= frame_num;
            rows_total   <= rows_total_d;
            reg_done_lat <= 1'b0;
            start_fe     <= 1'b1;
            busy         <= 1'b1;
            state        <= S_FE;
          end
        end
        S_FE: begin
          if (fe_exit) begin
            if (!frame_lat || (rows_total == '0)) begin
              done_pe <= 1'b1;
              state   <= S_DONE;
            end else begin
              start_registration <= 1'b1;
              row_sel_to_pe      <= '0;
              state              <= S_REG_START;
            end
          end
        end
        S_REG_START: begin
          state <= S_COMPARE;
        end
        S_COMPARE: begin
          // Registration may finish before the last row is scored; remember it.
          if (done_registration) reg_done_lat <= 1'b1;
          if (done_similarity_metric_i) begin
            if (cmp_last) state <= S_REG_WAIT;
            else          row_sel_to_pe <= row_nxt[ROW_LEN-1:0];
          end
        end
        S_REG_WAIT: begin
          if (rw_exit) begin
            done_pe       <= 1'b1;
            row_sel_to_pe <= '0;
            reg_done_lat  <= 1'b0;
            state         <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
`ifdef OFLOW_PE_CTRL_WATCHDOG_EN
      if (wdt_hit) begin
        wdt_err       <= 1'b1;
        done_pe       <= 1'b1;
        row_sel_to_pe <= '0;
        reg_done_lat  <= 1'b0;
        state         <= S_DONE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_oflow_pe_ctrl.sv
// tb_oflow_pe_ctrl
// Directed bench for oflow_pe_ctrl. Inputs change 1 ns after a rising edge;
// outputs are checked at that same point, i.e. they show the effect of the
// edge just taken. Define OFLOW_PE_CTRL_WATCHDOG_EN to build the watchdog
// variant (WDT_W = 4).
module tb_oflow_pe_ctrl;

  localparam int ROW_LEN   = 6;
  localparam int OBJ_CNT_W = 7;

  logic                 clk = 1'b0;
  logic                 reset_N = 1'b1;
  logic                 start_pe = 1'b0;
  logic                 frame_num = 1'b0;
  logic [OBJ_CNT_W-1:0] num_prev_objs = '0;
  logic                 done_fe = 1'b0;
  logic                 done_similarity_metric_i = 1'b0;
  logic                 done_registration = 1'b0;
  logic                 start_fe;
  logic                 start_registration;
  logic [ROW_LEN-1:0]   row_sel_to_pe;
  logic                 done_pe;
  logic                 busy;
`ifdef OFLOW_PE_CTRL_WATCHDOG_EN
  logic                 wdt_err;
`endif

  int total = 0;
  int bad   = 0;
  int sreg_cnt = 0;
  int dpe_cnt  = 0;
  int sfe_cnt  = 0;

  always #5 clk = ~clk;

`ifdef OFLOW_PE_CTRL_WATCHDOG_EN
  oflow_pe_ctrl #(.ROW_LEN(ROW_LEN), .OBJ_CNT_W(OBJ_CNT_W), .WDT_W(4)) dut (
`else
  oflow_pe_ctrl #(.ROW_LEN(ROW_LEN), .OBJ_CNT_W(OBJ_CNT_W)) dut (
`endif
    .clk                      (clk),
    .reset_N                  (reset_N),
    .start_pe                 (start_pe),
    .frame_num                (frame_num),
    .num_prev_objs            (num_prev_objs),
    .done_fe                  (done_fe),
    .done_similarity_metric_i (done_similarity_metric_i),
    .done_registration        (done_registration),
    .start_fe                 (start_fe),
    .start_registration       (start_registration),
    .row_sel_to_pe            (row_sel_to_pe),
    .done_pe                  (done_pe),
    .busy                     (busy)
`ifdef OFLOW_PE_CTRL_WATCHDOG_EN
    ,
    .wdt_err                  (wdt_err)
`endif
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (start_registration === 1'b1) sreg_cnt++;
    if (done_pe === 1'b1)            dpe_cnt++;
    if (start_fe === 1'b1)           sfe_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    sreg_cnt = 0;
    dpe_cnt  = 0;
    sfe_cnt  = 0;
  endtask

  task automatic test_reset();
    logic [ROW_LEN+3:0] outs;
    reset_N = 1'b1;
    tick();
    tick();
    outs = {start_fe, start_registration, row_sel_to_pe, done_pe, busy};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    reset_N = 1'b0;
    tick();
    outs = {start_fe, start_registration, row_sel_to_pe, done_pe, busy};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL idle_after_reset got=%h exp=0", outs);
    end
  endtask

  task automatic test_first_frame();
    clr_counts();
    frame_num = 1'b0;
    num_prev_objs = 7'd9;
    start_pe = 1'b1;
    tick();
    start_pe = 1'b0;
    total++;
    if (start_fe !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL ff_start_fe got=%b busy=%b exp=1 1", start_fe, busy);
    end
    for (int i = 1; i < 5; i++) begin
      if (i == 4) done_fe = 1'b1;
      tick();
      done_fe = 1'b0;
      if (i < 4) begin
        total++;
        if (done_pe !== 1'b0 || start_fe !== 1'b0) begin
          bad++;
          $display("FAIL ff_wait cyc=%0d done_pe=%b start_fe=%b exp=0 0", i, done_pe, start_fe);
        end
      end
    end
    total++;
    if (done_pe !== 1'b1 || row_sel_to_pe !== '0) begin
      bad++;
      $display("FAIL ff_done_pe got=%b row=%0d exp=1 0", done_pe, row_sel_to_pe);
    end
    tick();
    total++;
    if (done_pe !== 1'b0 || busy !== 1'b0 || sreg_cnt !== 0 || sfe_cnt !== 1) begin
      bad++;
      $display("FAIL ff_end done_pe=%b busy=%b sreg=%0d sfe=%0d exp=0 0 0 1",
               done_pe, busy, sreg_cnt, sfe_cnt);
    end
  endtask

  task automatic test_registration();
    logic [ROW_LEN-1:0] exp_row [3];
    exp_row[0] = 6'd1;
    exp_row[1] = 6'd2;
    exp_row[2] = 6'd2;
    clr_counts();
    frame_num = 1'b1;
    num_prev_objs = 7'd5;
    start_pe = 1'b1;
    tick();
    start_pe = 1'b0;
    done_fe = 1'b1;
    tick();
    done_fe = 1'b0;
    total++;
    if (start_registration !== 1'b1 || row_sel_to_pe !== 6'd0) begin
      bad++;
      $display("FAIL reg_start got=%b row=%0d exp=1 0", start_registration, row_sel_to_pe);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      done_similarity_metric_i = 1'b1;
      tick();
      done_similarity_metric_i = 1'b0;
      total++;
      if (row_sel_to_pe !== exp_row[i] || done_pe !== 1'b0) begin
        bad++;
        $display("FAIL reg_row step=%0d got=%0d exp=%0d done_pe=%b",
                 i, row_sel_to_pe, exp_row[i], done_pe);
      end
    end
    tick();
    total++;
    if (done_pe !== 1'b0 || busy !== 1'b1 || row_sel_to_pe !== 6'd2) begin
      bad++;
      $display("FAIL reg_wait done_pe=%b busy=%b row=%0d exp=0 1 2", done_pe, busy, row_sel_to_pe);
    end
    done_registration = 1'b1;
    tick();
    done_registration = 1'b0;
    total++;
    if (done_pe !== 1'b1 || row_sel_to_pe !== 6'd0) begin
      bad++;
      $display("FAIL reg_done got=%b row=%0d exp=1 0", done_pe, row_sel_to_pe);
    end
    tick();
    total++;
    if (sreg_cnt !== 1 || dpe_cnt !== 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reg_pulses sreg=%0d dpe=%0d busy=%b exp=1 1 0", sreg_cnt, dpe_cnt, busy);
    end
  endtask

  task automatic test_no_history();
    clr_counts();
    frame_num = 1'b1;
    num_prev_objs = 7'd0;
    start_pe = 1'b1;
    tick();
    start_pe = 1'b0;
    tick();
    done_fe = 1'b1;
    tick();
    done_fe = 1'b0;
    total++;
    if (done_pe !== 1'b1 || row_sel_to_pe !== 6'd0) begin
      bad++;
      $display("FAIL nohist_done got=%b row=%0d exp=1 0", done_pe, row_sel_to_pe);
    end
    tick();
    total++;
    if (sreg_cnt !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL nohist_sreg got=%0d busy=%b exp=0 0", sreg_cnt, busy);
    end
  endtask

  task automatic test_early_registration();
    clr_counts();
    frame_num = 1'b1;
    num_prev_objs = 7'd2;
    start_pe = 1'b1;
    tick();
    start_pe = 1'b0;
    done_fe = 1'b1;
    tick();
    done_fe = 1'b0;
    tick();
    done_registration = 1'b1;
    tick();
    done_registration = 1'b0;
    done_similarity_metric_i = 1'b1;
    tick();
    done_similarity_metric_i = 1'b0;
    total++;
    if (done_pe !== 1'b0 || row_sel_to_pe !== 6'd0) begin
      bad++;
      $display("FAIL early_enter got=%b row=%0d exp=0 0", done_pe, row_sel_to_pe);
    end
    tick();
    total++;
    if (done_pe !== 1'b1) begin
      bad++;
      $display("FAIL early_done got=%b exp=1", done_pe);
    end
    tick();
  endtask

  task automatic test_ignored_pulses();
    clr_counts();
    frame_num = 1'b1;
    num_prev_objs = 7'd3;
    start_pe = 1'b1;
    done_fe = 1'b1;
    tick();
    start_pe = 1'b0;
    done_fe = 1'b0;
    tick();
    tick();
    total++;
    if (start_registration !== 1'b0 || done_pe !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL same_cycle_fe sreg=%b done_pe=%b busy=%b exp=0 0 1",
               start_registration, done_pe, busy);
    end
    done_fe = 1'b1;
    tick();
    done_fe = 1'b0;
    tick();
    start_pe = 1'b1;
    tick();
    start_pe = 1'b0;
    total++;
    if (start_fe !== 1'b0) begin
      bad++;
      $display("FAIL busy_start got=%b exp=0", start_fe);
    end
    done_similarity_metric_i = 1'b1;
    tick();
    tick();
    done_similarity_metric_i = 1'b0;
    done_fe = 1'b1;
    tick();
    done_similarity_metric_i = 1'b1;
    tick();
    done_fe = 1'b0;
    done_similarity_metric_i = 1'b0;
    total++;
    if (done_pe !== 1'b0 || row_sel_to_pe !== 6'd1) begin
      bad++;
      $display("FAIL stray_in_wait done_pe=%b row=%0d exp=0 1", done_pe, row_sel_to_pe);
    end
    done_registration = 1'b1;
    tick();
    done_registration = 1'b0;
    tick();
    tick();
    total++;
    if (dpe_cnt !== 1 || sfe_cnt !== 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_done dpe=%0d sfe=%0d busy=%b exp=1 1 0", dpe_cnt, sfe_cnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [ROW_LEN+3:0] outs;
    clr_counts();
    frame_num = 1'b1;
    num_prev_objs = 7'd9;
    start_pe = 1'b1;
    tick();
    start_pe = 1'b0;
    done_fe = 1'b1;
    tick();
    done_fe = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      done_similarity_metric_i = 1'b1;
      tick();
      done_similarity_metric_i = 1'b0;
    end
    total++;
    if (row_sel_to_pe !== 6'd3) begin
      bad++;
      $display("FAIL mid_row got=%0d exp=3", row_sel_to_pe);
    end
    reset_N = 1'b1;
    tick();
    reset_N = 1'b0;
    outs = {start_fe, start_registration, row_sel_to_pe, done_pe, busy};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL mid_reset got=%h exp=0", outs);
    end
    done_registration = 1'b1;
    done_similarity_metric_i = 1'b1;
    done_fe = 1'b1;
    tick();
    done_registration = 1'b0;
    done_similarity_metric_i = 1'b0;
    done_fe = 1'b0;
    tick();
    outs = {start_fe, start_registration, row_sel_to_pe, done_pe, busy};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL post_reset_stray got=%h exp=0", outs);
    end
    frame_num = 1'b0;
    start_pe = 1'b1;
    tick();
    start_pe = 1'b0;
    total++;
    if (start_fe !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_start got=%b exp=1", start_fe);
    end
    done_fe = 1'b1;
    tick();
    done_fe = 1'b0;
    total++;
    if (done_pe !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_done got=%b exp=1", done_pe);
    end
    tick();
  endtask

`ifndef OFLOW_PE_CTRL_WATCHDOG_EN
  // 127 objects -> 64 rows: pointer climbs to 63 and stays there.
  task automatic test_saturate();
    clr_counts();
    frame_num = 1'b1;
    num_prev_objs = 7'd127;
    start_pe = 1'b1;
    tick();
    start_pe = 1'b0;
    done_fe = 1'b1;
    tick();
    done_fe = 1'b0;
    tick();
    done_similarity_metric_i = 1'b1;
    for (int i = 0; i < 63; i++) tick();
    total++;
    if (row_sel_to_pe !== 6'd63) begin
      bad++;
      $display("FAIL sat_row got=%0d exp=63", row_sel_to_pe);
    end
    tick();
    tick();
    done_similarity_metric_i = 1'b0;
    total++;
    if (row_sel_to_pe !== 6'd63 || done_pe !== 1'b0) begin
      bad++;
      $display("FAIL sat_hold row=%0d done_pe=%b exp=63 0", row_sel_to_pe, done_pe);
    end
    done_registration = 1'b1;
    tick();
    done_registration = 1'b0;
    total++;
    if (done_pe !== 1'b1 || row_sel_to_pe !== 6'd0) begin
      bad++;
      $display("FAIL sat_done got=%b row=%0d exp=1 0", done_pe, row_sel_to_pe);
    end
    tick();
  endtask
`else
  task automatic test_watchdog();
    clr_counts();
    frame_num = 1'b0;
    start_pe = 1'b1;
    tick();
    start_pe = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      total++;
      if (done_pe !== 1'b0 || wdt_err !== 1'b0) begin
        bad++;
        $display("FAIL wdt_early cyc=%0d done_pe=%b wdt_err=%b exp=0 0", i, done_pe, wdt_err);
      end
    end
    tick();
    total++;
    if (done_pe !== 1'b1 || wdt_err !== 1'b1) begin
      bad++;
      $display("FAIL wdt_fire done_pe=%b wdt_err=%b exp=1 1", done_pe, wdt_err);
    end
    tick();
    total++;
    if (wdt_err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL wdt_after wdt_err=%b busy=%b exp=0 0", wdt_err, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_frame();
    test_registration();
    test_no_history();
    test_early_registration();
    test_ignored_pulses();
    test_reset_mid();
`ifndef OFLOW_PE_CTRL_WATCHDOG_EN
    test_saturate();
`else
    test_watchdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oflow_pe_ctrl.md
Name: oflow_pe_ctrl

Overview:
Per-PE sequencer that drives one oflow_pe through a full object pass. Steps: feature extraction, then registration against previous-frame objects, with the buffer row pointer stepped per similarity-metric completion, then done_pe to the core FSM. Sits between oflow_core_fsm and oflow_pe; the core FSM issues one start per bbox and sees one done_pe back.

Parameters:
ROW_LEN, 6, width of row_sel_to_pe; buffer holds 2^ROW_LEN rows, two objects per row.
OBJ_CNT_W, 7, width of num_prev_objs.
WDT_W, 10, watchdog counter width (optional feature only).

Ports:
clk  in  1  clock, rising edge.
reset_N  in  1  synchronous, active-high reset (1 = reset), sampled on rising clk.
start_pe  in  1  one-cycle pulse from core FSM: new bbox valid at PE input.
frame_num  in  1  0 = first frame (no history), 1 = later frame; sampled on start_pe.
num_prev_objs  in  OBJ_CNT_W  previous-frame object count; sampled on start_pe.
done_fe  in  1  pulse from feature extraction.
done_similarity_metric_i  in  1  pulse: current row pair scored.
done_registration  in  1  pulse: registration/scoreboard result final.
start_fe  out  1  one-cycle pulse to feature extraction.
start_registration  out  1  one-cycle pulse to registration.
row_sel_to_pe  out  ROW_LEN  buffer row driving data_to_pe_0/1.
done_pe  out  1  one-cycle pulse to core FSM and PE.
busy  out  1  high from accepted start_pe until done_pe cycle inclusive.

Behaviour:
- Reset (reset_N=1 at a clk edge): state IDLE; all outputs 0; latched frame_num/num_prev_objs cleared. Applies mid-operation; in-flight input pulses are ignored afterwards.
- States: IDLE, FE, REG_START, COMPARE, REG_WAIT, DONE.
- IDLE: on start_pe, latch frame_num, num_prev_objs; rows_total = ceil(num_prev_objs/2) computed at OBJ_CNT_W bits, truncated to ROW_LEN+1. Next cycle -> FE with start_fe=1 for that one cycle (latency start_pe->start_fe = 1 clk).
- FE: wait done_fe. If latched frame_num=0 or rows_total=0 -> DONE. Else -> REG_START.
- REG_START: start_registration=1 for one cycle, row_sel_to_pe=0 -> COMPARE.
- COMPARE: each done_similarity_metric_i increments row counter. If counter+1 == rows_total -> REG_WAIT, row_sel_to_pe holds the last row. Else row_sel_to_pe increments.
- REG_WAIT: wait done_registration -> DONE. If done_registration arrives in COMPARE on or before the final done_similarity_metric_i, it is latched and REG_WAIT exits the cycle after entry.
- DONE: done_pe=1 one cycle -> IDLE; row_sel_to_pe returns to 0.
- start_pe while busy: ignored; no queuing.
- done_fe / done_similarity_metric_i / done_registration outside their waiting state: ignored, except the done_registration latch described above.
- done_fe and start_pe in the same cycle in IDLE: start_pe accepted, done_fe ignored.
- Minimum pass, first frame: start_pe(t), start_fe(t+1), done_fe(t+k), done_pe(t+k+1).
- row_sel_to_pe never exceeds rows_total-1; num_prev_objs>2^(ROW_LEN+1) saturates rows_total at 2^ROW_LEN.

Optional Feature:
OFLOW_PE_CTRL_WATCHDOG_EN
- Defined: adds output wdt_err (1 bit) and a WDT_W-bit counter. The counter clears on every state change and increments each cycle in FE/COMPARE/REG_WAIT.
- On reaching all-ones: wdt_err pulses one cycle, the FSM forces DONE (done_pe pulses), then returns to IDLE.
- Undefined: no counter and no port; waits are unbounded.

Decomposition:
- oflow_pe_ctrl_pkg: state enum pe_ctrl_state_t, ROW_LEN/OBJ_CNT_W defaults, rows_total helper function.
- No sub-module: the watchdog is a small always_ff inside the block.

Test Plan:
- Reset mid-COMPARE (row_sel=3), reset_N=1 one cycle -> next cycle all outputs 0, state IDLE; a subsequent start_pe runs normally.
- frame_num=0, start_pe at t, done_fe at t+5 -> start_fe at t+1, no start_registration, done_pe at t+6.
- frame_num=1, num_prev_objs=5 -> start_registration once; row_sel 0,1,2 after successive done_similarity_metric_i; then done_registration -> done_pe next cycle, row_sel back to 0.
- frame_num=1, num_prev_objs=0 -> behaves as first frame; row_sel stays 0.
- start_pe pulsed during COMPARE and stray done_fe in REG_WAIT -> no effect; single done_pe.
- WATCHDOG_EN with WDT_W=4, done_fe never asserted -> wdt_err and done_pe 16 cycles after FE entry.
